// File: rtl/zap_btb_pkg.sv
// Shared types for the BTB update path: scheduler FSM states, the queued
// feedback record and the index function also used by the BTB itself.
package zap_btb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    QUIET = 2'd2
  } t_upd_state;

  typedef struct packed {
    logic        nok;
    logic [31:0] src;
    logic [1:0]  state;
    logic [31:0] dest;
  } t_btb_fb;

  // Halfword-aligned index: addr[$clog2(entries):1] for power-of-2 entries.
  function automatic logic [31:0] btb_index(input logic [31:0] addr, input int entries);
    btb_index = (addr >> 1) & $unsigned(entries - 1);
  endfunction

endpackage

// File: rtl/zap_btb_upd_fifo.sv
// Synchronous feedback FIFO with flush, occupancy count and an in-place
// write port on the youngest entry (used for index coalescing).
import zap_btb_pkg::*;

module zap_btb_upd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   coalesce,
  input  t_btb_fb                wr_data,
  output t_btb_fb                head,
  output t_btb_fb                youngest,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  t_btb_fb        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  young_idx;

  assign wr_idx    = wr_ptr[AW-1:0];
  assign young_idx = wr_idx - AW'(1);
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head      = mem[rd_ptr[AW-1:0]];
  assign youngest  = mem[young_idx];

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_idx] <= wr_data;
    else if (coalesce)
      mem[young_idx] <= wr_data;
  end

endmodule

// File: rtl/zap_btb_upd_sched.sv
// BTB update scheduler: queues branch feedback, drains one write per cycle
// and sequences full-table invalidation. Optional ZAP_BTB_UPD_COALESCE_EN.
import zap_btb_pkg::*;

module zap_btb_upd_sched #(
  parameter int BP_ENTRIES   = 1024,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_CNT_WDT = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_fb_ok,
  input  logic                    i_fb_nok,
  input  logic [31:0]             i_fb_src,
  input  logic [1:0]              i_fb_state,
  input  logic [31:0]             i_fb_dest,
  input  logic                    i_hold,
  input  logic                    i_inv_req,
  output logic                    o_btb_fb_ok,
  output logic                    o_btb_fb_nok,
  output logic [31:0]             o_btb_src,
  output logic [1:0]              o_btb_state,
  output logic [31:0]             o_btb_dest,
  output logic                    o_btb_clear,
  output logic                    o_inv_busy,
  output logic                    o_inv_done,
  output logic                    o_empty,
  output logic [DROP_CNT_WDT-1:0] o_drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  t_upd_state     state;
  t_btb_fb        fb_entry;
  t_btb_fb        head;
  t_btb_fb        youngest;
  logic           fb_valid;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           push;
  logic           pop;
  logic           coalesce;
  logic           drop;
  logic           flush;

  assign fb_valid = i_fb_ok | i_fb_nok;
  assign fb_entry = '{nok: i_fb_nok, src: i_fb_src, state: i_fb_state, dest: i_fb_dest};
  assign o_empty  = fifo_empty && !o_btb_fb_ok && !o_btb_fb_nok;

  // Outside RUN, and in the cycle an invalidate arrives, feedback is
  // discarded uncounted so pre-clear updates can never reach the table.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    coalesce = 1'b0;
    drop     = 1'b0;
    flush    = 1'b0;
    if (state == RUN) begin
      if (i_inv_req) begin
        flush = 1'b1;
      end else begin
        pop = !fifo_empty && !i_hold;
`ifdef ZAP_BTB_UPD_COALESCE_EN
        coalesce = fb_valid && !fifo_empty &&
                   (btb_index(i_fb_src, BP_ENTRIES) == btb_index(youngest.src, BP_ENTRIES)) &&
                   !(pop && fifo_count == CW'(1));
`endif
        push = fb_valid && !coalesce && (!fifo_full || pop);
        drop = fb_valid && !coalesce && fifo_full && !pop;
      end
    end
  end

  zap_btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .coalesce (coalesce),
    .wr_data  (fb_entry),
    .head     (head),
    .youngest (youngest),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= RUN;
      o_btb_fb_ok  <= 1'b0;
      o_btb_fb_nok <= 1'b0;
      o_btb_src    <= '0;
      o_btb_state  <= '0;
      o_btb_dest   <= '0;
      o_btb_clear  <= 1'b0;
      o_inv_busy   <= 1'b0;
      o_inv_done   <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      o_btb_fb_ok  <= 1'b0;
      o_btb_fb_nok <= 1'b0;
      o_btb_clear  <= 1'b0;
      o_inv_done   <= 1'b0;
      if (pop) begin
        o_btb_fb_ok  <= !head.nok;
        o_btb_fb_nok <= head.nok;
        o_btb_src    <= head.src;
        o_btb_state  <= head.state;
        o_btb_dest   <= head.dest;
      end
      if (drop && o_drop_cnt != '1)
        o_drop_cnt <= o_drop_cnt + DROP_CNT_WDT'(1);
      case (state)
        RUN: begin
          if (i_inv_req) begin
            state       <= CLEAR;
            o_btb_clear <= 1'b1;
            o_inv_busy  <= 1'b1;
          end
        end
        CLEAR: state <= QUIET;
        QUIET: begin
          state      <= RUN;
          o_inv_busy <= 1'b0;
          o_inv_done <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/zap_btb_upd_sched.md
Name: zap_btb_upd_sched

Overview:
Update scheduler sitting between branch-resolution feedback (execute/writeback) and the branch target buffer's feedback write port.
- Buffers resolved-branch feedback in a small FIFO.
- Serialises at most one BTB write per cycle.
- Sequences full-table invalidation requests, e.g. CP15 or context switch.
- Keeps a saturating count of feedback lost to overflow.
- All BTB-facing outputs are registered.

Parameters:
BP_ENTRIES, 1024, BTB entry count (power of 2); index = addr[$clog2(BP_ENTRIES):1].
FIFO_DEPTH, 4, feedback queue depth (power of 2, >=2).
DROP_CNT_WDT, 8, width of overflow drop counter.

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_fb_ok  in  1  branch prediction correct.
i_fb_nok  in  1  branch mispredicted.
i_fb_src  in  32  branch source address.
i_fb_state  in  2  predicted state at issue.
i_fb_dest  in  32  resolved target address.
i_hold  in  1  suspend draining (queue still accepts).
i_inv_req  in  1  single-cycle pulse: invalidate entire BTB.
o_btb_fb_ok  out  1  registered write strobe (ok) to BTB.
o_btb_fb_nok  out  1  registered write strobe (nok) to BTB.
o_btb_src  out  32  registered source address.
o_btb_state  out  2  registered state.
o_btb_dest  out  32  registered target.
o_btb_clear  out  1  registered BTB clear pulse.
o_inv_busy  out  1  invalidation in progress.
o_inv_done  out  1  one-cycle pulse on invalidation completion.
o_empty  out  1  queue empty and no write in flight.
o_drop_cnt  out  DROP_CNT_WDT  saturating count of dropped feedback.

Behaviour:
- Reset values: all strobes, o_btb_clear, o_inv_busy and o_inv_done are 0; addresses/state 0; o_empty 1; o_drop_cnt 0; FIFO pointers 0; FSM RUN.
- Feedback valid = i_fb_ok | i_fb_nok. If both are high, treat as nok (ok strobe not forwarded).
- Queue entry = {nok, src, state, dest}.
- FSM RUN:
  - Push on valid feedback when not full, or when full with a pop in the same cycle.
  - Pop when non-empty and !i_hold. The popped entry drives the o_btb_* registers at the next edge with exactly one strobe high.
  - When not popping, both strobes are 0 and the data registers hold their value.
  - Minimum latency: feedback at edge N appears on o_btb_* after edge N+1. Writes stay in strict FIFO order.
- Overflow: feedback arriving when full with no pop is dropped and o_drop_cnt increments, saturating at all-ones.
- i_inv_req in RUN -> state CLEAR at the next edge:
  - FIFO flushed (pointers reset).
  - o_btb_clear = 1 for exactly one cycle; o_btb_fb_* strobes = 0.
  - o_inv_busy = 1.
- CLEAR -> QUIET for one cycle:
  - Feedback is dropped silently with no count, so stale pre-clear updates cannot write.
  - o_inv_busy = 1.
- QUIET -> RUN with an o_inv_done pulse. Queue accepts again from that cycle.
- i_inv_req while in CLEAR or QUIET is ignored (merged).
- Feedback in the same cycle as i_inv_req is dropped without counting.
- o_empty = FIFO empty and no strobe asserted this cycle.
- Reset mid-operation aborts everything and returns to the reset values.

Optional Feature:
Macro ZAP_BTB_UPD_COALESCE_EN.
- Defined: if incoming feedback's index equals the index of the youngest queued entry, and that entry is not being popped this cycle, overwrite that entry in place; the count is unchanged. This also applies when the queue is full, so no drop occurs.
- Undefined: every valid feedback is pushed as a separate entry.

Decomposition:
- Shared package zap_btb_pkg: FSM state enum {RUN, CLEAR, QUIET}; t_btb_fb struct {nok, src, state, dest}; index-extraction function, also reused by the BTB itself.
- One sub-module: zap_btb_upd_fifo, a synchronous FIFO with count, full/empty, flush, and youngest-entry write port for coalescing.

Test Plan:
- Reset, then one ok with src=0x100, state=2, dest=0x200 -> after 2 edges o_btb_fb_ok=1 for 1 cycle with matching fields; o_empty back to 1.
- i_hold=1, push 6 feedbacks (FIFO_DEPTH=4) -> 4 queued, o_drop_cnt=2; release i_hold -> 4 writes on consecutive cycles, in order.
- ok and nok both high, src=0x40 -> o_btb_fb_nok=1, o_btb_fb_ok=0.
- 3 entries queued with i_hold=1, then i_inv_req -> o_btb_clear pulse 1 cycle, o_inv_busy for 2 cycles, o_inv_done 1 cycle, zero BTB writes; feedback during QUIET not written and o_drop_cnt unchanged.
- Drive overflow 300 times with DROP_CNT_WDT=8 -> o_drop_cnt saturates at 255.
- Coalesce enabled, i_hold=1, two feedbacks src=0x80 then 0x80+2*BP_ENTRIES -> single entry with the second's fields; disabled -> two entries.
